fpexp_align: RTL and testbench

Parametrised exponent-alignment sequencer for the floating-point add/subtract path: the successor to the fixed 8-bit/40-bit exponent compare-and-count logic inside the FP microoperation unit. It takes the two operand exponents (T and C) and forms their signed difference at full width. It derives the G/WDT/WT indicators, then issues one denormalising-shift request per cycle to the mantissa datapath under a ready handshake, with abort support. It produces the result exponent and a completion pulse.

---
 rtl/fpexp_align.sv | 138 +++++++++++++
 tb/tb_fpexp_align.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fpexp_align.sv
// Exponent-alignment sequencer for the FP add/subtract path: compares the T and C exponents,
// picks the operand to denormalise and issues one right-shift request per accepted cycle.
module fpexp_align #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 40,
    parameter int unsigned CNT_W  = $clog2(MANT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [EXP_W-1:0] exp_t_i,
    input  logic [EXP_W-1:0] exp_c_i,
    input  logic             zero_t_i,
    input  logic             zero_c_i,
    input  logic             shift_rdy_i,
    output logic             busy_o,
    output logic             shift_t_o,
    output logic             shift_c_o,
    output logic             done_o,
    output logic             g_o,
    output logic             wdt_o,
    output logic             wt_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [EXP_W-1:0] exp_r_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StShift, StDone} state_e;

    state_e           state_q;
    logic [EXP_W-1:0] exp_t_q, exp_c_q, exp_r_q;
    logic             zero_t_q, zero_c_q;
    logic [EXP_W:0]   diff_d, diff_q, diff_mag;
    logic             too_far;
    logic [CNT_W-1:0] cnt_q;
    logic             g_q, wdt_q, wt_q;

    // One extra bit keeps the sign-extended difference exact for any exponent pair.
    assign diff_d   = {exp_t_i[EXP_W-1], exp_t_i} - {exp_c_i[EXP_W-1], exp_c_i};
    assign diff_mag = diff_q[EXP_W] ? (~diff_q + 1'b1) : diff_q;
    assign too_far  = 32'(diff_mag) >= MANT_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            exp_t_q  <= '0;
            exp_c_q  <= '0;
            zero_t_q <= 1'b0;
            zero_c_q <= 1'b0;
            diff_q   <= '0;
            cnt_q    <= '0;
            g_q      <= 1'b0;
            wdt_q    <= 1'b0;
            wt_q     <= 1'b0;
            exp_r_q  <= '0;
        end else if (abort_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        exp_t_q  <= exp_t_i;
                        exp_c_q  <= exp_c_i;
                        zero_t_q <= zero_t_i;
                        zero_c_q <= zero_c_i;
                        diff_q   <= diff_d;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    state_q <= StDone;
                    cnt_q   <= '0;
                    if (zero_c_q) begin
                        g_q     <= 1'b1;
                        wt_q    <= 1'b1;
                        wdt_q   <= 1'b0;
                        exp_r_q <= exp_t_q;
                    end else if (zero_t_q) begin
                        g_q     <= 1'b1;
                        wt_q    <= 1'b0;
                        wdt_q   <= 1'b1;
                        exp_r_q <= exp_c_q;
                    end else if (diff_q == '0) begin
                        g_q     <= 1'b0;
                        wt_q    <= 1'b0;
                        wdt_q   <= 1'b0;
                        exp_r_q <= exp_t_q;
                    end else if (!diff_q[EXP_W]) begin
                        // T is larger: C gets denormalised, or T passes straight through.
                        wdt_q   <= 1'b0;
                        exp_r_q <= exp_t_q;
                        g_q     <= too_far;
                        wt_q    <= too_far;
                        if (!too_far) begin
                            cnt_q   <= CNT_W'(diff_mag);
                            state_q <= StShift;
                        end
                    end else begin
                        wdt_q   <= 1'b1;
                        exp_r_q <= exp_c_q;
                        g_q     <= too_far;
                        wt_q    <= 1'b0;
                        if (!too_far) begin
                            cnt_q   <= CNT_W'(diff_mag);
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    if (shift_rdy_i) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o    = state_q != StIdle;
    assign done_o    = (state_q == StDone) && !abort_i;
    assign shift_t_o = (state_q == StShift) && wdt_q && shift_rdy_i && !abort_i;
    assign shift_c_o = (state_q == StShift) && !wdt_q && shift_rdy_i && !abort_i;
    assign g_o       = g_q;
    assign wdt_o     = wdt_q;
    assign wt_o      = wt_q;
    assign cnt_o     = cnt_q;
    assign exp_r_o   = exp_r_q;

endmodule

// File: tb/tb_fpexp_align.sv
// Directed and randomized bench for fpexp_align with a cycle-timeline reference model.
module tb_fpexp_align;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, zero_t = 1'b0, zero_c = 1'b0, shift_rdy = 1'b0;
    logic [7:0] exp_t = '0, exp_c = '0;
    logic       busy, shift_t, shift_c, done, g, wdt, wt;
    logic [5:0] cnt;
    logic [7:0] exp_r;

    int checks = 0;
    int errors = 0;
    int p_g = 0, p_wdt = 0, p_wt = 0, p_er = 0;

    fpexp_align #(.EXP_W(8), .MANT_W(40)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .exp_t_i(exp_t), .exp_c_i(exp_c), .zero_t_i(zero_t), .zero_c_i(zero_c),
        .shift_rdy_i(shift_rdy), .busy_o(busy), .shift_t_o(shift_t), .shift_c_o(shift_c),
        .done_o(done), .g_o(g), .wdt_o(wdt), .wt_o(wt), .cnt_o(cnt), .exp_r_o(exp_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_flags(input int eg, input int ewdt, input int ewt, input int eer);
        chk("g", int'(g), eg);
        chk("wdt", int'(wdt), ewdt);
        chk("wt", int'(wt), ewt);
        chk("exp_r", int'(exp_r), eer);
    endtask

    task automatic chk_idle();
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_shift_t", int'(shift_t), 0);
        chk("idle_shift_c", int'(shift_c), 0);
        chk("idle_cnt", int'(cnt), 0);
    endtask

    // One operation. rdy_mask bit k is shift_rdy during cycle k (cycle 0 = start cycle).
    // abort_k / start_k / rst_k select a cycle for abort, a spurious start, or async reset.
    task automatic run(input logic [7:0] t, input logic [7:0] c, input logic zt, input logic zc,
                       input logic [63:0] rdy_mask, input int abort_k, input int start_k,
                       input int rst_k);
        int  ti, ci, d, n, mg, mwdt, mwt, mer, s;
        bit  fin, calc_done, sh;
        ti = int'($signed(t));
        ci = int'($signed(c));
        d  = ti - ci;
        n  = 0;
        if (zc) begin
            mg = 1; mwt = 1; mwdt = 0; mer = int'(t);
        end else if (zt) begin
            mg = 1; mwt = 0; mwdt = 1; mer = int'(c);
        end else if (d == 0) begin
            mg = 0; mwt = 0; mwdt = 0; mer = int'(t);
        end else if (d > 0) begin
            mwdt = 0; mer = int'(t);
            if (d >= 40) begin mg = 1; mwt = 1; end
            else begin mg = 0; mwt = 0; n = d; end
        end else begin
            mwdt = 1; mer = int'(c); mwt = 0;
            if (-d >= 40) mg = 1;
            else begin mg = 0; n = -d; end
        end

        @(negedge clk);
        start = 1'b1; abort = 1'b0; shift_rdy = rdy_mask[0];
        exp_t = t; exp_c = c; zero_t = zt; zero_c = zc;
        #1;
        chk_idle();
        chk_flags(p_g, p_wdt, p_wt, p_er);

        s = 0; fin = 1'b0; calc_done = 1'b0;
        for (int k = 1; k < 200 && !fin; k++) begin
            @(negedge clk);
            start     = (k == start_k);
            abort     = (k == abort_k);
            shift_rdy = (k < 64) ? rdy_mask[k] : 1'b1;
            exp_t     = 8'($urandom);
            exp_c     = 8'($urandom);
            zero_t    = 1'($urandom);
            zero_c    = 1'($urandom);
            if (k == rst_k) begin
                #1 rst_n = 1'b0;
                #1;
                chk_idle();
                chk_flags(0, 0, 0, 0);
                p_g = 0; p_wdt = 0; p_wt = 0; p_er = 0;
                calc_done = 1'b0;
                start = 1'b0;
                #1 rst_n = 1'b1;
                fin = 1'b1;
            end else begin
                #1;
                chk("busy", int'(busy), 1);
                if (k == 1) begin
                    chk("calc_done", int'(done), 0);
                    chk("calc_shift_t", int'(shift_t), 0);
                    chk("calc_shift_c", int'(shift_c), 0);
                    chk("calc_cnt", int'(cnt), 0);
                    chk_flags(p_g, p_wdt, p_wt, p_er);
                end else begin
                    chk_flags(mg, mwdt, mwt, mer);
                    if (s < n) begin
                        sh = shift_rdy && !abort;
                        chk("done_early", int'(done), 0);
                        chk("cnt", int'(cnt), n - s);
                        chk("shift_t", int'(shift_t), int'(sh && mwdt == 1));
                        chk("shift_c", int'(shift_c), int'(sh && mwdt == 0));
                        if (sh) s++;
                    end else begin
                        chk("done", int'(done), int'(!abort));
                        chk("done_cnt", int'(cnt), 0);
                        chk("done_shift", int'(shift_t || shift_c), 0);
                        fin = 1'b1;
                    end
                end
                if (k >= 1 && !(k == 1 && abort)) calc_done = 1'b1;
                if (abort) fin = 1'b1;
            end
        end
        if (!fin) chk("timeout", 1, 0);
        if (calc_done) begin
            p_g = mg; p_wdt = mwdt; p_wt = mwt; p_er = mer;
        end

        @(negedge clk);
        start = 1'b0; abort = 1'b0; shift_rdy = 1'b1;
        #1;
        chk_idle();
        chk_flags(p_g, p_wdt, p_wt, p_er);
    endtask

    initial begin
        logic [63:0] mask;
        logic [7:0]  rt, rc;
        #3;
        chk_idle();
        chk_flags(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(8'd5, 8'd2, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'hF6, 8'd30, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'hF6, 8'd28, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'd127, 8'h80, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'h80, 8'd127, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'd17, 8'd17, 1'b0, 1'b1, '1, -1, -1, -1);
        run(8'd17, 8'd17, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'd3, 8'd9, 1'b1, 1'b0, '1, -1, -1, -1);
        run(8'd42, 8'd3, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'd0, 8'd39, 1'b0, 1'b0, '1, -1, -1, -1);
        mask = ~64'h18;
        run(8'd0, 8'd3, 1'b0, 1'b0, mask, -1, -1, -1);
        run(8'd10, 8'd0, 1'b0, 1'b0, '1, 3, -1, -1);
        run(8'd4, 8'd1, 1'b0, 1'b0, '1, -1, -1, -1);
        run(8'd20, 8'd10, 1'b0, 1'b0, '1, -1, -1, 4);
        run(8'd1, 8'd11, 1'b0, 1'b0, '1, -1, 3, -1);
        run(8'd2, 8'd1, 1'b0, 1'b0, '1, 2, -1, -1);

        for (int i = 0; i < 40; i++) begin
            rt = 8'($urandom);
            rc = ($urandom_range(0, 3) != 0) ? 8'(rt - 8'($urandom_range(0, 90) - 45)) :
                                               8'($urandom);
            mask = {$urandom, $urandom} | {$urandom, $urandom};
            run(rt, rc, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, mask,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : -1,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 10)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
